sp_mem_responder: RTL and testbench
===================================

Name: sp_mem_responder

Overview:
- Memory-side responder for the SP core's SRAM port (sram_ADDR/DI/EN/WE/DO).
- Serves the CTL initiator with a fixed 1-cycle read latency, backed by a single-port word array.
- Posts SP writes into a one-entry write buffer, so the array port is free for reads and buffered writes drain in the background.
- Adds a lower-priority host port with an en/ack handshake, used for program/data preload and result dump while the core is idle.

Parameters:
ADDR_W, 16, word-address width on both ports
DATA_W, 32, data word width
DEPTH, 65536, number of array words; must be ≤ 2^ADDR_W

Ports:
clk        input   1       single clock, all logic on rising edge
reset      input   1       asynchronous reset, active-low
sram_ADDR  input   ADDR_W  SP word address
sram_DI    input   DATA_W  SP write data
sram_EN    input   1       SP access request, single cycle, no stall
sram_WE    input   1       1 = write, 0 = read (qualified by sram_EN)
sram_DO    output  DATA_W  SP read data, registered
host_en    input   1       host request; held until host_ack
host_we    input   1       host write/read select, stable while host_en is high
host_addr  input   ADDR_W  host word address, stable while host_en is high
host_di    input   DATA_W  host write data
host_do    output  DATA_W  host read data, valid while host_ack is high
host_ack   output  1       one-cycle completion pulse

Behaviour:
- Reset (reset low, async):
  - sram_DO=0, host_do=0, host_ack=0.
  - Write buffer valid (wb_v) cleared; a pending write is discarded.
  - Array contents are not reset.
- Write buffer: registers wb_v, wb_addr, wb_data.
- SP read (EN=1, WE=0) at cycle N:
  - sram_DO updates at edge N+1 and holds until the next SP read.
  - If wb_v and wb_addr==sram_ADDR, the read forwards wb_data; otherwise it returns the array word.
  - The array is read this cycle and no drain occurs.
- SP write (EN=1, WE=1) at cycle N:
  - If wb_v is set, the old entry is written to the array in cycle N.
  - The new write is latched into the buffer at edge N+1 (wb_v=1).
  - The buffer never overflows: occupancy stays ≤ 1 by construction.
  - A bench assertion fires if an SP write ever arrives while a drain is blocked.
- Array op arbitration, one op per cycle, priority high to low:
  - (1) SP read.
  - (2) Buffer drain. Happens on any cycle without an SP read, including idle cycles; clears wb_v unless refilled the same cycle.
  - (3) Host access. Granted only when host_en=1, sram_EN=0 and wb_v=0.
- Host handshake:
  - A grant in cycle N performs the array op in cycle N.
  - host_ack=1 for exactly cycle N+1. For reads, host_do is valid in that same cycle.
  - The host must drop host_en, or present a new request, in cycle N+1. host_en still high at N+1 is taken as a new request.
  - A host request is never granted in the cycle it is acked.
  - The host may starve under continuous SP traffic; this is accepted.
- Ordering: a host access is only granted once wb_v=0, so the host always observes all prior SP writes.
- Out-of-range address (addr ≥ DEPTH), either port: reads return 0 and writes are dropped. For SP writes the drop happens at drain time.
- Reset asserted mid host request: the ack is lost and the host must re-request after reset.
- Reset asserted while wb_v=1: the buffered write is lost.
- sram_EN with X on sram_WE is illegal (bench assertion).

Decomposition:
- Shared package sp_mem_pkg holds:
  - the ADDR_W/DATA_W defaults;
  - an op-select enum {OP_IDLE, OP_SP_RD, OP_DRAIN, OP_HOST_RD, OP_HOST_WR};
  - a wb_entry struct {v, addr, data}.
- One sub-module, sp_mem_array: single-port synchronous word RAM (DEPTH×DATA_W) with a registered read port and no reset.
- Arbitration, the write buffer, forwarding and the host handshake live in the top.

Test Plan:
- SP write addr 0x0010 ← 0xDEADBEEF, then SP read 0x0010 the next cycle -> sram_DO=0xDEADBEEF one cycle after the read (forwarded), and the array holds 0xDEADBEEF after the next non-read cycle.
- SP writes 0x0001←0x11, 0x0002←0x22, 0x0003←0x33 on back-to-back cycles, then reads 1,2,3 -> DO sequence 0x11, 0x22, 0x33, and wb_v ≤ 1 throughout.
- Host write 0x0100←0xCAFE0001 while SP idle -> host_ack one cycle after host_en. A following host read of 0x0100 -> host_do=0xCAFE0001 with the ack.
- Host read of 0x0020 asserted during 5 consecutive SP reads after an SP write to 0x0020 ← 0x5 -> no ack during SP traffic. After the drain, the host is granted and host_do=0x5.
- Read and write of address 0xFFFF with DEPTH=1024 -> DO=0 and the array is unchanged.
- Reset pulled low with wb_v=1 and a host request pending -> sram_DO=0, host_ack=0, wb_v=0 immediately. After reset release, the host re-request completes normally.

Source files
------------

// File: rtl/sp_mem_responder_pkg.sv
// Shared defaults, array-op select and write-buffer entry type for the SP memory responder.
`timescale 1ns/1ps
package sp_mem_pkg;

  localparam int SP_ADDR_W = 16;
  localparam int SP_DATA_W = 32;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_SP_RD,
    OP_DRAIN,
    OP_HOST_RD,
    OP_HOST_WR
  } op_e;

  typedef struct packed {
    logic                 v;
    logic [SP_ADDR_W-1:0] addr;
    logic [SP_DATA_W-1:0] data;
  } wb_entry_t;

  // Addresses at or above the array depth read as zero and never write.
  function automatic logic addr_in_range(input logic [SP_ADDR_W-1:0] addr,
                                         input int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/sp_mem_responder_if.sv
// SP SRAM port plus host preload/dump port, bundled for the responder.
`timescale 1ns/1ps
interface sp_mem_responder_if
  import sp_mem_pkg::*;
#(
  parameter int ADDR_W = SP_ADDR_W,
  parameter int DATA_W = SP_DATA_W
);

  logic [ADDR_W-1:0] sram_ADDR;
  logic [DATA_W-1:0] sram_DI;
  logic              sram_EN;
  logic              sram_WE;
  logic [DATA_W-1:0] sram_DO;

  logic              host_en;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_di;
  logic [DATA_W-1:0] host_do;
  logic              host_ack;

  modport master (
    output sram_ADDR, sram_DI, sram_EN, sram_WE,
    output host_en, host_we, host_addr, host_di,
    input  sram_DO, host_do, host_ack
  );

  modport slave (
    input  sram_ADDR, sram_DI, sram_EN, sram_WE,
    input  host_en, host_we, host_addr, host_di,
    output sram_DO, host_do, host_ack
  );

endinterface

// File: rtl/sp_mem_responder_array.sv
// Single-port synchronous word RAM with a registered read port; contents are never reset.
`timescale 1ns/1ps
module sp_mem_array #(
  parameter int DEPTH  = 65536,
  parameter int DATA_W = 32,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // rdata only moves on a read, so it holds across writes and idle cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sp_mem_responder.sv
// SP SRAM responder: 1-cycle reads, one-entry posted write buffer, low-priority host port.
`timescale 1ns/1ps
module sp_mem_responder
  import sp_mem_pkg::*;
#(
  parameter int          ADDR_W = SP_ADDR_W,
  parameter int          DATA_W = SP_DATA_W,
  parameter int unsigned DEPTH  = 65536
) (
  input  logic              clk,
  input  logic              reset,
  sp_mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  op_e               op;
  wb_entry_t         wb_q;
  wb_entry_t         wb_d;
  logic              sp_rd;
  logic              sp_wr;
  logic              arr_en;
  logic              arr_we;
  logic              arr_ok;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] sp_do;

  logic              sp_rd_q;
  logic              fwd_q;
  logic              oor_q;
  logic              host_ack_q;
  logic              host_rd_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] do_hold_q;

  assign sp_rd = bus.sram_EN && !bus.sram_WE;
  assign sp_wr = bus.sram_EN &&  bus.sram_WE;

  // One array op per cycle: SP read, then drain, then host. The host also waits out
  // the cycle it is being acked in and any SP write, so it always sees prior SP writes.
  always_comb begin
    op = OP_IDLE;
    if (sp_rd) begin
      op = OP_SP_RD;
    end else if (wb_q.v) begin
      op = OP_DRAIN;
    end else if (bus.host_en && !bus.sram_EN && !host_ack_q) begin
      op = bus.host_we ? OP_HOST_WR : OP_HOST_RD;
    end
  end

  always_comb begin
    arr_addr  = bus.sram_ADDR;
    arr_wdata = wb_q.data;
    arr_we    = 1'b0;
    unique case (op)
      OP_SP_RD:   arr_addr = bus.sram_ADDR;
      OP_DRAIN: begin
        arr_addr = wb_q.addr;
        arr_we   = 1'b1;
      end
      OP_HOST_RD: arr_addr = bus.host_addr;
      OP_HOST_WR: begin
        arr_addr  = bus.host_addr;
        arr_wdata = bus.host_di;
        arr_we    = 1'b1;
      end
      default: ;
    endcase
    arr_ok = addr_in_range(arr_addr, DEPTH);
    arr_en = (op != OP_IDLE) && arr_ok;
  end

  // A refill in the same cycle as a drain keeps the buffer occupied.
  always_comb begin
    wb_d = wb_q;
    if (op == OP_DRAIN) begin
      wb_d.v = 1'b0;
    end
    if (sp_wr) begin
      wb_d = '{v: 1'b1, addr: bus.sram_ADDR, data: bus.sram_DI};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q       <= '0;
      sp_rd_q    <= 1'b0;
      fwd_q      <= 1'b0;
      oor_q      <= 1'b0;
      host_ack_q <= 1'b0;
      host_rd_q  <= 1'b0;
      fwd_data_q <= '0;
      do_hold_q  <= '0;
    end else begin
      wb_q       <= wb_d;
      sp_rd_q    <= (op == OP_SP_RD);
      host_ack_q <= (op == OP_HOST_RD) || (op == OP_HOST_WR);
      host_rd_q  <= (op == OP_HOST_RD);
      oor_q      <= !arr_ok;
      if (op == OP_SP_RD) begin
        fwd_q      <= wb_q.v && (wb_q.addr == bus.sram_ADDR);
        fwd_data_q <= wb_q.data;
      end
      if (sp_rd_q) begin
        do_hold_q <= sp_do;
      end
    end
  end

  // sram_DO shows the fresh read result for one cycle, then the held copy.
  always_comb begin
    sp_do = do_hold_q;
    if (sp_rd_q) begin
      if (oor_q) begin
        sp_do = '0;
      end else if (fwd_q) begin
        sp_do = fwd_data_q;
      end else begin
        sp_do = rdata;
      end
    end
  end

  assign bus.sram_DO  = sp_do;
  assign bus.host_ack = host_ack_q;
  assign bus.host_do  = (host_ack_q && host_rd_q && !oor_q) ? rdata : '0;

  sp_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr[IDX_W-1:0]),
    .wdata (arr_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sp_mem_responder.sv
// Scoreboard bench for sp_mem_responder: SP and host expectations queued at drive time.
`timescale 1ns/1ps
module tb_sp_mem_responder;
  import sp_mem_pkg::*;

  localparam int unsigned DEPTH = 1024;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
  } host_exp_t;

  logic clk;
  logic reset;

  int n_compared;
  int n_mismatched;

  logic [31:0] sp_exp_q [$];
  host_exp_t   host_exp_q [$];
  logic [31:0] model_mem [int];
  logic        sp_rd_prev;

  sp_mem_responder_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  sp_mem_responder #(
    .ADDR_W (16),
    .DATA_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [15:0] addr);
    if (32'(addr) >= DEPTH) return 32'h0;
    if (model_mem.exists(int'(addr))) return model_mem[int'(addr)];
    return 32'h0;
  endfunction

  function automatic void modelWrite(input logic [15:0] addr, input logic [31:0] data);
    if (32'(addr) < DEPTH) model_mem[int'(addr)] = data;
  endfunction

  // One SP cycle: en/we/addr/data driven 1ns after the edge; reads queue their expectation.
  task automatic applyStimulus(input bit en, input bit we, input logic [15:0] addr,
                               input logic [31:0] data);
    @(posedge clk);
    #1;
    bus.sram_EN   = en;
    bus.sram_WE   = we;
    bus.sram_ADDR = addr;
    bus.sram_DI   = data;
    if (en && !we) sp_exp_q.push_back(modelRead(addr));
    if (en && we) modelWrite(addr, data);
  endtask

  // Full host handshake; exp_lat (edges from request to visible ack) is checked when nonzero.
  task automatic hostAccess(input bit we, input logic [15:0] addr, input logic [31:0] data,
                            input int exp_lat);
    host_exp_t e;
    int        lat;
    bit        got;
    @(posedge clk);
    #1;
    bus.host_en   = 1'b1;
    bus.host_we   = we;
    bus.host_addr = addr;
    bus.host_di   = data;
    e.is_rd = !we;
    e.data  = we ? 32'h0 : modelRead(addr);
    host_exp_q.push_back(e);
    if (we) modelWrite(addr, data);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.host_ack === 1'b1) got = 1'b1;
    end
    checkOutput("host_ack_seen", 32'(got), 32'd1);
    if (exp_lat > 0) checkOutput("host_ack_latency", lat, exp_lat);
    bus.host_en = 1'b0;
    @(negedge clk);
    checkOutput("host_ack_pulse", 32'(bus.host_ack), 32'd0);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) sp_rd_prev <= 1'b0;
    else        sp_rd_prev <= (bus.sram_EN === 1'b1) && (bus.sram_WE === 1'b0);
  end

  // Scoreboard: SP results appear the cycle after a read, host results with the ack.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (sp_rd_prev) begin
        if (sp_exp_q.size() == 0) checkOutput("sp_unexpected_read", 32'd1, 32'd0);
        else checkOutput("sram_DO", bus.sram_DO, sp_exp_q.pop_front());
      end
      if (bus.host_ack === 1'b1) begin
        if (host_exp_q.size() == 0) begin
          checkOutput("host_unexpected_ack", 32'd1, 32'd0);
        end else begin
          host_exp_t e;
          e = host_exp_q.pop_front();
          if (e.is_rd) checkOutput("host_do", bus.host_do, e.data);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      assert (!(bus.sram_EN === 1'b1 && $isunknown(bus.sram_WE)))
        else $error("[TB] assertion: sram_EN with unknown sram_WE");
      assert (!(bus.sram_EN === 1'b1 && bus.sram_WE === 1'b1 && dut.wb_q.v && dut.op != OP_DRAIN))
        else $error("[TB] assertion: SP write arrived while buffer drain was blocked");
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    reset         = 1'b0;
    bus.sram_EN   = 1'b0;
    bus.sram_WE   = 1'b0;
    bus.sram_ADDR = '0;
    bus.sram_DI   = '0;
    bus.host_en   = 1'b0;
    bus.host_we   = 1'b0;
    bus.host_addr = '0;
    bus.host_di   = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_sram_DO", bus.sram_DO, 32'h0);
    checkOutput("reset_host_ack", 32'(bus.host_ack), 32'd0);
    checkOutput("reset_host_do", bus.host_do, 32'h0);
    checkOutput("reset_wb_v", 32'(dut.wb_q.v), 32'd0);
    reset = 1'b1;

    $display("[TB] write then forwarded read");
    applyStimulus(1, 1, 16'h0010, 32'hDEADBEEF);
    applyStimulus(1, 0, 16'h0010, 32'h0);
    @(negedge clk);
    checkOutput("wb_v_after_write", 32'(dut.wb_q.v), 32'd1);
    applyStimulus(0, 0, 16'h0, 32'h0);
    applyStimulus(1, 0, 16'h0010, 32'h0);
    @(negedge clk);
    checkOutput("wb_v_after_drain", 32'(dut.wb_q.v), 32'd0);

    $display("[TB] back-to-back writes");
    applyStimulus(1, 1, 16'h0001, 32'h11);
    applyStimulus(1, 1, 16'h0002, 32'h22);
    applyStimulus(1, 1, 16'h0003, 32'h33);
    for (int i = 1; i <= 3; i++) applyStimulus(1, 0, 16'(i), 32'h0);
    applyStimulus(0, 0, 16'h0, 32'h0);

    $display("[TB] host write and read while SP idle");
    hostAccess(1, 16'h0100, 32'hCAFE0001, 1);
    hostAccess(0, 16'h0100, 32'h0, 1);

    $display("[TB] host read starved by SP reads");
    applyStimulus(1, 1, 16'h0020, 32'h5);
    fork
      hostAccess(0, 16'h0020, 32'h0, 7);
      begin
        applyStimulus(1, 0, 16'h0020, 32'h0);
        applyStimulus(1, 0, 16'h0001, 32'h0);
        applyStimulus(1, 0, 16'h0002, 32'h0);
        applyStimulus(1, 0, 16'h0100, 32'h0);
        applyStimulus(1, 0, 16'h0003, 32'h0);
        applyStimulus(0, 0, 16'h0, 32'h0);
      end
    join

    $display("[TB] out-of-range accesses");
    hostAccess(1, 16'h03FF, 32'hA5A5A5A5, 1);
    applyStimulus(1, 1, 16'hFFFF, 32'h12345678);
    applyStimulus(1, 0, 16'hFFFF, 32'h0);
    applyStimulus(0, 0, 16'h0, 32'h0);
    applyStimulus(1, 0, 16'h03FF, 32'h0);
    applyStimulus(0, 0, 16'h0, 32'h0);
    applyStimulus(0, 0, 16'h0, 32'h0);
    @(negedge clk);
    checkOutput("sram_DO_hold", bus.sram_DO, 32'hA5A5A5A5);
    hostAccess(1, 16'hFFFF, 32'h87654321, 1);
    hostAccess(0, 16'hFFFF, 32'h0, 1);

    $display("[TB] reset with buffered write and pending host request");
    hostAccess(1, 16'h0040, 32'h00004444, 1);
    hostAccess(1, 16'h0041, 32'h00005555, 1);
    applyStimulus(1, 1, 16'h0040, 32'h77);
    applyStimulus(1, 1, 16'h0041, 32'h88);
    bus.host_en   = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 16'h0040;
    #2;
    reset       = 1'b0;
    bus.sram_EN = 1'b0;
    bus.host_en = 1'b0;
    #1;
    checkOutput("midreset_sram_DO", bus.sram_DO, 32'h0);
    checkOutput("midreset_host_ack", 32'(bus.host_ack), 32'd0);
    checkOutput("midreset_wb_v", 32'(dut.wb_q.v), 32'd0);
    modelWrite(16'h0040, 32'h00004444);
    modelWrite(16'h0041, 32'h00005555);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    hostAccess(0, 16'h0040, 32'h0, 1);
    hostAccess(0, 16'h0041, 32'h0, 1);
    hostAccess(1, 16'h0040, 32'h00001234, 1);
    hostAccess(0, 16'h0040, 32'h0, 1);

    repeat (2) @(negedge clk);
    checkOutput("sp_queue_empty", sp_exp_q.size(), 32'd0);
    checkOutput("host_queue_empty", host_exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
